spart_rx_cfg: RTL and testbench

Next-generation SPART receiver, parametrised in frame format, with an on-board receive FIFO. It deserialises asynchronous serial frames: 1 start bit, DATA_W data bits sent LSB first, an optional parity bit, and STOP_BITS stop bits. Each frame is pushed with its error flags into a first-word-fall-through FIFO. It sits between the rxd pad and the SPART control/bus interface, replacing the single-byte shift-register receiver.

---
 rtl/spart_pkg.sv | 19 +
 rtl/spart_fifo.sv | 57 +++++
 rtl/spart_rx_cfg.sv | 211 +++++++++++++++++++++
 tb/tb_spart_rx_cfg.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// Shared SPART types: receiver state encoding, divisor floor and the FIFO entry layout.
// SPART_RX_ENTRY_T(W) expands to the {ferr, perr, data[W-1:0]} packed struct for a given data width.
`define SPART_RX_ENTRY_T(W) struct packed { logic ferr; logic perr; logic [(W)-1:0] data; }

package spart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_HIGH
   } rx_state_t;

   localparam int unsigned SPART_DIV_MIN = 4;
   localparam int unsigned SPART_FLAG_W  = 2;

endpackage

// File: rtl/spart_fifo.sv
// Generic synchronous first-word-fall-through FIFO; the head entry is shown combinationally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module spart_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_empty,
   output logic                     o_full,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_drop
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == CW'(DEPTH));
   assign w_pop   = i_pop & ~o_empty;
   assign w_push  = i_push & (~o_full | i_pop);
   assign o_drop  = i_push & o_full & ~i_pop;
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/spart_rx_cfg.sv
// SPART receiver: configurable frame format, errors carried with each entry into an FWFT FIFO.
// SPART_RX_MAJORITY_EN selects 2-of-3 majority sampling around each bit centre.
//   IDLE      | line high, waiting for a start edge
//   START     | half-bit wait, confirm start bit low
//   DATA      | shifting DATA_W bits in, LSB first
//   PARITY    | checking the parity bit
//   STOP      | checking stop bits, pushes the entry on the last one
//   WAIT_HIGH | after a framing error, hold until the line returns high
module spart_rx_cfg
   import spart_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int STOP_BITS = 1,
   parameter int DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rxd,
   input  logic [15:0]            divisor,
   input  logic                   parity_en,
   input  logic                   parity_odd,
   input  logic                   rd_en,
   input  logic                   ovr_clr,
   output logic [DATA_W-1:0]      rx_data,
   output logic                   rx_perr,
   output logic                   rx_ferr,
   output logic                   rx_empty,
   output logic                   rx_full,
   output logic [$clog2(DEPTH):0] rx_count,
   output logic                   overrun
);

   typedef `SPART_RX_ENTRY_T(DATA_W) rx_entry_t;

   logic              r_sync1;
   logic              r_sync2;
   rx_state_t         r_state;
   rx_state_t         w_state_nxt;
   logic [15:0]       r_timer;
   logic [15:0]       r_div;
   logic              r_par_en;
   logic              r_par_odd;
   logic [DATA_W-1:0] r_shift;
   logic [3:0]        r_bit_cnt;
   logic [1:0]        r_stop_cnt;
   logic              r_perr;
   logic              r_ferr;
   logic              r_ovr;

   logic              w_rxd_s;
   logic [15:0]       w_div_in;
   logic              w_tick;
   logic              w_evt;
   logic              w_bit;
   logic              w_start;
   logic              w_push;
   logic              w_drop;
   logic              w_ferr_now;
   logic              w_last_data;
   logic              w_last_stop;
   rx_entry_t         w_entry;
   rx_entry_t         w_head;

   assign w_rxd_s     = r_sync2;
   assign w_div_in    = (divisor < 16'(SPART_DIV_MIN)) ? 16'(SPART_DIV_MIN) : divisor;
   assign w_tick      = (r_timer == '0);
   assign w_ferr_now  = r_ferr | ~w_bit;
   assign w_last_data = (r_bit_cnt == 4'(DATA_W - 1));
   assign w_last_stop = (r_stop_cnt == 2'(STOP_BITS - 1));

`ifdef SPART_RX_MAJORITY_EN
   logic r_tick_d;
   logic r_samp1;
   logic r_samp0;

   // Decisions lag the tick by one clock so the third sample can be taken; the bit period is unchanged.
   assign w_evt = r_tick_d;
   assign w_bit = (r_samp1 & r_samp0) | (r_samp1 & w_rxd_s) | (r_samp0 & w_rxd_s);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tick_d <= 1'b0;
         r_samp1  <= 1'b1;
         r_samp0  <= 1'b1;
      end else begin
         r_tick_d <= w_tick & (r_state != IDLE);
         if (r_timer == 16'd1) r_samp1 <= w_rxd_s;
         if (w_tick)           r_samp0 <= w_rxd_s;
      end
   end
`else
   assign w_evt = w_tick;
   assign w_bit = w_rxd_s;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_state <= IDLE;
      end else begin
         r_sync1 <= rxd;
         r_sync2 <= r_sync1;
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_rxd_s) begin
               w_start     = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_evt) w_state_nxt = w_bit ? IDLE : DATA;
         end
         DATA: begin
            if (w_evt && w_last_data) w_state_nxt = r_par_en ? PARITY : STOP;
         end
         PARITY: begin
            if (w_evt) w_state_nxt = STOP;
         end
         STOP: begin
            if (w_evt && w_last_stop) begin
               w_push      = 1'b1;
               w_state_nxt = w_ferr_now ? WAIT_HIGH : IDLE;
            end
         end
         WAIT_HIGH: begin
            if (w_rxd_s) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_timer    <= '0;
         r_div      <= '0;
         r_par_en   <= 1'b0;
         r_par_odd  <= 1'b0;
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= '0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
      end else if (w_start) begin
         r_timer    <= w_div_in >> 1;
         r_div      <= w_div_in;
         r_par_en   <= parity_en;
         r_par_odd  <= parity_odd;
         r_bit_cnt  <= '0;
         r_stop_cnt <= '0;
         r_perr     <= 1'b0;
         r_ferr     <= 1'b0;
      end else if (r_state != IDLE) begin
         r_timer <= w_tick ? r_div : r_timer - 1'b1;
         if (w_evt) begin
            case (r_state)
               DATA: begin
                  r_shift   <= {w_bit, r_shift[DATA_W-1:1]};
                  r_bit_cnt <= r_bit_cnt + 4'd1;
               end
               PARITY: r_perr <= (^r_shift) ^ w_bit ^ r_par_odd;
               STOP: begin
                  r_ferr     <= w_ferr_now;
                  r_stop_cnt <= r_stop_cnt + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

   assign w_entry.ferr = w_ferr_now;
   assign w_entry.perr = r_perr;
   assign w_entry.data = r_shift;

   spart_fifo #(
      .WIDTH (DATA_W + SPART_FLAG_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_entry),
      .i_pop   (rd_en),
      .o_data  (w_head),
      .o_empty (rx_empty),
      .o_full  (rx_full),
      .o_count (rx_count),
      .o_drop  (w_drop)
   );

   // A same-cycle clear loses to a fresh overrun.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_ovr <= 1'b0;
      else      r_ovr <= (r_ovr & ~ovr_clr) | w_drop;
   end

   assign overrun = r_ovr;
   assign rx_data = w_head.data;
   assign rx_perr = w_head.perr;
   assign rx_ferr = w_head.ferr;

endmodule

// File: tb/tb_spart_rx_cfg.sv
// Scoreboard bench for spart_rx_cfg: frames are built bit by bit from their format rules and the
// expected FIFO entry is queued at send time; a monitor checks every pop against the queue.
module tb_spart_rx_cfg;

   localparam int DATA_W    = 8;
   localparam int STOP_BITS = 1;
   localparam int DEPTH     = 4;
   localparam int CW        = $clog2(DEPTH) + 1;

   typedef struct {
      logic              ferr;
      logic              perr;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              rxd;
   logic [15:0]       divisor;
   logic              parity_en;
   logic              parity_odd;
   logic              rd_en;
   logic              ovr_clr;
   logic [DATA_W-1:0] rx_data;
   logic              rx_perr;
   logic              rx_ferr;
   logic              rx_empty;
   logic              rx_full;
   logic [CW-1:0]     rx_count;
   logic              overrun;

   exp_t exp_q[$];
   logic exp_ovr;
   int   checks;
   int   failures;

   spart_rx_cfg #(
      .DATA_W    (DATA_W),
      .STOP_BITS (STOP_BITS),
      .DEPTH     (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .divisor    (divisor),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .rd_en      (rd_en),
      .ovr_clr    (ovr_clr),
      .rx_data    (rx_data),
      .rx_perr    (rx_perr),
      .rx_ferr    (rx_ferr),
      .rx_empty   (rx_empty),
      .rx_full    (rx_full),
      .rx_count   (rx_count),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic chk_reset();
      chk("rst_empty", 32'(rx_empty), 32'd1);
      chk("rst_full", 32'(rx_full), 32'd0);
      chk("rst_count", 32'(rx_count), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      chk("rst_data", 32'(rx_data), 32'd0);
      chk("rst_perr", 32'(rx_perr), 32'd0);
      chk("rst_ferr", 32'(rx_ferr), 32'd0);
   endtask

   // Negedges after the start-bit negedge until the one just before the push clock:
   // two synchroniser clocks, one IDLE decision clock, half a bit, then whole bits.
   function automatic int push_neg(input int d, input bit pe);
      return 3 + d / 2 + (DATA_W + int'(pe) + STOP_BITS) * (d + 1);
   endfunction

   // Monitor: every pop handshake is compared with the oldest expected entry.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #3;
         if (rst && rd_en && !rx_empty) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL pop_unexpected got data=%0h perr=%0b ferr=%0b exp=none", rx_data, rx_perr, rx_ferr);
            end else begin
               e = exp_q.pop_front();
               if ({rx_ferr, rx_perr, rx_data} !== {e.ferr, e.perr, e.data}) begin
                  failures++;
                  $display("FAIL pop_entry got data=%0h perr=%0b ferr=%0b exp data=%0h perr=%0b ferr=%0b",
                           rx_data, rx_perr, rx_ferr, e.data, e.perr, e.ferr);
               end
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic send_frame(input logic [DATA_W-1:0] data, input int d, input bit pe, input bit po,
                             input bit bad_par, input bit bad_stop, input int hold_low,
                             input int rst_at, input bit with_pop);
      bit   bits[$];
      exp_t e;
      bit   pb;
      bit   aborted;
      pb = bit'($countones(data) % 2) ^ po;
      bits.push_back(1'b0);
      for (int b = 0; b < DATA_W; b++) bits.push_back(data[b]);
      if (pe) bits.push_back(pb ^ bad_par);
      for (int s = 0; s < STOP_BITS; s++) bits.push_back(!(bad_stop && s == 0));
      e.data = data;
      e.perr = pe & bad_par;
      e.ferr = bad_stop;
      if (rst_at < 0) begin
         if (exp_q.size() < DEPTH || with_pop) exp_q.push_back(e);
         else exp_ovr = 1'b1;
      end
      divisor    = 16'(d);
      parity_en  = pe;
      parity_odd = po;
      @(negedge clk);
      aborted = 1'b0;
      for (int i = 0; i < bits.size() && !aborted; i++) begin
         rxd = bits[i];
         if (i == rst_at) begin
            repeat ((d + 1) / 2) @(negedge clk);
            rst = 1'b0;
            rxd = 1'b1;
            exp_q.delete();
            exp_ovr = 1'b0;
            #1;
            chk_reset();
            repeat (3) @(negedge clk);
            rst = 1'b1;
            aborted = 1'b1;
         end else begin
            repeat (d + 1) @(negedge clk);
            // Mid-frame divisor changes must not disturb the frame in flight.
            if (i == 0) divisor = 16'($urandom_range(4, 60));
         end
      end
      if (!aborted) begin
         if (hold_low > 0) begin
            rxd = 1'b0;
            repeat (hold_low * (d + 1)) @(negedge clk);
         end
         rxd = 1'b1;
         repeat (d + 5) @(negedge clk);
      end else begin
         repeat (4) @(negedge clk);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 2; i++) begin
         @(negedge clk);
         rd_en = ~rx_empty;
      end
      @(negedge clk);
      rd_en = 1'b0;
      chk("drain_empty", 32'(rx_empty), 32'd1);
      chk("drain_sb_left", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int d;
      checks     = 0;
      failures   = 0;
      exp_ovr    = 1'b0;
      rst        = 1'b0;
      rxd        = 1'b1;
      divisor    = 16'd15;
      parity_en  = 1'b0;
      parity_odd = 1'b0;
      rd_en      = 1'b0;
      ovr_clr    = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // 0x55 with the push timing pinned down.
      fork
         send_frame(8'h55, 15, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0);
         begin
            @(negedge clk);
            repeat (push_neg(15, 1'b0)) @(negedge clk);
            chk("empty_before_push", 32'(rx_empty), 32'd1);
            @(negedge clk);
            chk("empty_after_push", 32'(rx_empty), 32'd0);
         end
      join
      chk("count_one", 32'(rx_count), 32'(exp_q.size()));
      drain();

      // Parity: 0xA3 has four ones, so even parity wants 0 and odd parity wants 1; drive 1 both times.
      send_frame(8'hA3, 15, 1'b1, 1'b0, 1'b1, 1'b0, 0, -1, 1'b0);
      send_frame(8'hA3, 15, 1'b1, 1'b1, 1'b0, 1'b0, 0, -1, 1'b0);
      drain();

      // Bad stop bit then a held-low line: one entry only, then a clean frame.
      send_frame(8'h5A, 15, 1'b0, 1'b0, 1'b0, 1'b1, 3, -1, 1'b0);
      chk("break_one_entry", 32'(rx_count), 32'(exp_q.size()));
      send_frame(8'h3C, 15, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0);
      drain();

      // Start glitch of 4 clocks.
      divisor = 16'd15;
      @(negedge clk);
      rxd = 1'b0;
      repeat (4) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_count", 32'(rx_count), 32'd0);

      // Overflow: five frames, no reads.
      for (int f = 1; f <= 5; f++) send_frame(DATA_W'(f), 15, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0);
      chk("fill_count", 32'(rx_count), 32'(DEPTH));
      chk("fill_full", 32'(rx_full), 32'd1);
      chk("fill_overrun", 32'(overrun), 32'(exp_ovr));
      chk("fill_head", 32'(rx_data), 32'h01);
      drain();
      chk("ovr_sticky", 32'(overrun), 32'd1);
      @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      exp_ovr = 1'b0;
      chk("ovr_cleared", 32'(overrun), 32'(exp_ovr));

      // Reset in the 4th data bit with entries pending, then a clean 0x9E.
      send_frame(8'h11, 15, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0);
      send_frame(8'h22, 15, 1'b1, 1'b1, 1'b1, 1'b0, 0, -1, 1'b0);
      send_frame(8'hC7, 15, 1'b0, 1'b0, 1'b0, 1'b0, 0, 4, 1'b0);
      send_frame(8'h9E, 15, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0);
      chk("post_rst_count", 32'(rx_count), 32'd1);
      drain();

      // Push and pop in the same clock while full.
      for (int f = 0; f < DEPTH; f++)
         send_frame(DATA_W'($urandom), 15, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b0);
      fork
         send_frame(8'hE1, 15, 1'b0, 1'b0, 1'b0, 1'b0, 0, -1, 1'b1);
         begin
            @(negedge clk);
            repeat (push_neg(15, 1'b0)) @(negedge clk);
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            chk("pushpop_count_edge", 32'(rx_count), 32'(DEPTH));
         end
      join
      chk("pushpop_count", 32'(rx_count), 32'(DEPTH));
      chk("pushpop_overrun", 32'(overrun), 32'(exp_ovr));
      drain();

      // Randomised formats and error injection.
      for (int n = 0; n < 14; n++) begin
         d = $urandom_range(4, 20);
         send_frame(DATA_W'($urandom), d, 1'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0), 0, -1, 1'b0);
         chk("rand_count", 32'(rx_count), 32'(exp_q.size()));
         if (exp_q.size() >= 2) drain();
      end
      drain();
      chk("final_overrun", 32'(overrun), 32'(exp_ovr));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
